// File: rtl/lfsr_checker.sv
// PRBS checker for a Galois LFSR stream: self-seeds from the incoming words, locks after
// LOCK_CNT consecutive matches, then counts word/bit errors and unlocks after UNLOCK_CNT misses.
module lfsr_checker #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = '0,
  parameter int                    LOCK_CNT   = 4,
  parameter int                    UNLOCK_CNT = 8,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} state_t;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int PW = $clog2(DATA_WIDTH + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                st_q, st_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [MW-1:0]         mc_q, mc_d;
  logic [BW-1:0]         bc_q, bc_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  ec_q, ec_d, bec_q, bec_d;

  logic [DATA_WIDTH-1:0] diff;
  logic [PW-1:0]         pop;
  logic [SW-1:0]         bsum;
  logic                  hit;

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
    lfsr_next = {1'b0, x[DATA_WIDTH-1:1]} ^
                ({DATA_WIDTH{x[0]}} & {1'b1, POLY[DATA_WIDTH-2:0]});
  endfunction

  always_comb begin
    diff = dat_i ^ exp_q;
    hit  = (diff == '0);
    pop  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + PW'(diff[i]);
    // Wide sum so an overflowing bit-error addition can be detected and clamped.
    bsum = SW'(bec_q) + SW'(pop);
  end

  always_comb begin
    st_d  = st_q;
    exp_d = exp_q;
    mc_d  = mc_q;
    bc_d  = bc_q;
    err_d = 1'b0;
    ec_d  = ec_q;
    bec_d = bec_q;
    if (!en_i) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE: st_d = SEED;
        SEED: if (vld_i) begin
          exp_d = lfsr_next(dat_i);
          mc_d  = '0;
          st_d  = VERIFY;
        end
        VERIFY: if (vld_i) begin
          if (hit) begin
            exp_d = lfsr_next(exp_q);
            mc_d  = mc_q + MW'(1);
            if (mc_q == MW'(LOCK_CNT - 1)) begin
              st_d = LOCKED;
              bc_d = '0;
            end
          end else begin
            exp_d = lfsr_next(dat_i);
            mc_d  = '0;
          end
        end
        LOCKED: if (vld_i) begin
          exp_d = lfsr_next(exp_q);
          if (hit) begin
            bc_d = '0;
          end else begin
            err_d = 1'b1;
            ec_d  = (ec_q == CNT_MAX) ? ec_q : ec_q + CNT_WIDTH'(1);
            bec_d = (bsum > SW'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(bsum);
            bc_d  = bc_q + BW'(1);
            if (bc_q == BW'(UNLOCK_CNT - 1)) begin
              st_d = SEED;
              bc_d = '0;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
    // Clear beats any same-cycle error increment.
    if (clr_i) begin
      ec_d  = '0;
      bec_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      exp_q <= '0;
      mc_q  <= '0;
      bc_q  <= '0;
      err_q <= 1'b0;
      ec_q  <= '0;
      bec_q <= '0;
    end else begin
      st_q  <= st_d;
      exp_q <= exp_d;
      mc_q  <= mc_d;
      bc_q  <= bc_d;
      err_q <= err_d;
      ec_q  <= ec_d;
      bec_q <= bec_d;
    end
  end

  assign locked_o      = (st_q == LOCKED);
  assign err_o         = err_q;
  assign err_cnt_o     = ec_q;
  assign bit_err_cnt_o = bec_q;
  assign state_o       = st_q;

endmodule
